// File: rtl/fir_mac_prog_if.sv
// Sample/coefficient input and filtered output bundle for fir_mac_prog.
// master drives samples and coefficients; slave is the filter.
interface fir_mac_prog_if #(
  parameter int BW_in   = 4,
  parameter int BW_coef = 4,
  parameter int BW_out  = 8
);
  logic signed [BW_in-1:0]   x_in;
  logic                      in_valid;
  logic                      coef_load;
  logic signed [BW_coef-1:0] coef_in;
  logic signed [BW_out-1:0]  y_out;
  logic                      out_valid;
  logic                      busy;
  logic                      overrun;

  modport master (
    output x_in, in_valid, coef_load, coef_in,
    input  y_out, out_valid, busy, overrun
  );

  modport slave (
    input  x_in, in_valid, coef_load, coef_in,
    output y_out, out_valid, busy, overrun
  );
endinterface

// File: rtl/fir_mac_prog.sv
// Programmable N-tap FIR using one time-multiplexed MAC; result N_TAPS edges after the sample edge.
// No backpressure: samples/loads arriving while busy (or a sample colliding with a load) are dropped and flagged in sticky overrun.
module fir_mac_prog #(
  parameter int N_TAPS  = 4,
  parameter int BW_in   = 4,
  parameter int BW_coef = 4,
  parameter int BW_out  = 8,
  parameter int SHIFT   = 0
) (
  input  logic           clk,
  input  logic           reset,
  fir_mac_prog_if.slave  bus
);
  localparam int PW = BW_in + BW_coef;
  localparam int AW = PW + $clog2(N_TAPS);
  localparam int RW = AW + 1;
  localparam int IW = $clog2(N_TAPS);
  localparam logic [IW-1:0]           LAST  = IW'(N_TAPS - 1);
  localparam logic signed [RW-1:0]    RND   = RW'((2 ** SHIFT) / 2);
  localparam logic signed [RW-1:0]    MAXV  = RW'((2 ** (BW_out - 1)) - 1);
  localparam logic signed [RW-1:0]    MINV  = -MAXV - RW'(1);
  localparam logic signed [BW_coef-1:0] H_M1 = '1;
  localparam logic signed [BW_coef-1:0] H_P1 = BW_coef'(1);

  typedef enum logic {IDLE, MAC} state_t;

  state_t                    state_q, state_d;
  logic signed [BW_in-1:0]   x_q [N_TAPS];
  logic signed [BW_in-1:0]   x_d [N_TAPS];
  logic signed [BW_coef-1:0] h_q [N_TAPS];
  logic signed [BW_coef-1:0] h_d [N_TAPS];
  logic [IW-1:0]             idx_q, idx_d;
  logic signed [AW-1:0]      acc_q, acc_d;
  logic signed [BW_out-1:0]  y_q, y_d;
  logic                      out_valid_q, out_valid_d;
  logic                      overrun_q, overrun_d;

  logic signed [PW-1:0]      prod;
  logic signed [AW-1:0]      acc_sum;
  logic signed [RW-1:0]      rnd;
  logic signed [RW-1:0]      shr;
  logic signed [BW_out-1:0]  y_sat;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!bus.coef_load && bus.in_valid) state_d = MAC;
      MAC:  if (idx_q == LAST)                  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are widened before multiplying so the product never wraps.
  always_comb begin
    prod    = PW'(x_q[idx_q]) * PW'(h_q[idx_q]);
    acc_sum = acc_q + AW'(prod);
    rnd     = RW'(acc_sum) + RND;
    shr     = rnd >>> SHIFT;
    if (shr > MAXV)      y_sat = BW_out'(MAXV);
    else if (shr < MINV) y_sat = BW_out'(MINV);
    else                 y_sat = BW_out'(shr);
  end

  always_comb begin
    x_d         = x_q;
    h_d         = h_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    y_d         = y_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    case (state_q)
      IDLE: begin
        if (bus.coef_load) begin
          for (int k = 0; k < N_TAPS - 1; k++) h_d[k] = h_q[k+1];
          h_d[N_TAPS-1] = bus.coef_in;
          if (bus.in_valid) overrun_d = 1'b1;
        end else if (bus.in_valid) begin
          for (int k = 1; k < N_TAPS; k++) x_d[k] = x_q[k-1];
          x_d[0] = bus.x_in;
          acc_d  = '0;
          idx_d  = '0;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        idx_d = idx_q + IW'(1);
        if (bus.in_valid || bus.coef_load) overrun_d = 1'b1;
        if (idx_q == LAST) begin
          y_d         = y_sat;
          out_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Reset coefficients give y[n] = x[n-1] - x[n].
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_TAPS; k++) begin
        x_q[k] <= '0;
        h_q[k] <= '0;
      end
      h_q[0]      <= H_M1;
      h_q[1]      <= H_P1;
      idx_q       <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      x_q         <= x_d;
      h_q         <= h_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.y_out     = y_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == MAC);
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_fir_mac_prog.sv
// Bench for fir_mac_prog: SHIFT=0 and SHIFT=2 instances, directed samples, queue scoreboard.
module tb_fir_mac_prog;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  logic signed [3:0] x_in = '0;
  logic signed [3:0] coef_in = '0;
  logic in_valid = 1'b0;
  logic coef_load = 1'b0;

  int checks = 0;
  int errors = 0;
  int q0[$];
  int q1[$];

  always #5 clk = ~clk;

  fir_mac_prog_if #(.BW_in(4), .BW_coef(4), .BW_out(8)) if0 ();
  fir_mac_prog_if #(.BW_in(4), .BW_coef(4), .BW_out(8)) if1 ();

  assign if0.x_in      = x_in;
  assign if0.coef_in   = coef_in;
  assign if0.in_valid  = in_valid & ~sel;
  assign if0.coef_load = coef_load & ~sel;
  assign if1.x_in      = x_in;
  assign if1.coef_in   = coef_in;
  assign if1.in_valid  = in_valid & sel;
  assign if1.coef_load = coef_load & sel;

  fir_mac_prog #(.N_TAPS(N), .BW_in(4), .BW_coef(4), .BW_out(8), .SHIFT(0))
    u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  fir_mac_prog #(.N_TAPS(N), .BW_in(4), .BW_coef(4), .BW_out(8), .SHIFT(2))
    u_dut1 (.clk(clk), .reset(reset), .bus(if1));

  wire out_valid_m = sel ? if1.out_valid : if0.out_valid;
  wire busy_m      = sel ? if1.busy      : if0.busy;
  wire overrun_m   = sel ? if1.overrun   : if0.overrun;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (if0.out_valid) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out0 got %0d expected none", int'(if0.y_out));
      end else check("y_out0", int'(if0.y_out), q0.pop_front());
    end
    if (if1.out_valid) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out1 got %0d expected none", int'(if1.y_out));
      end else check("y_out1", int'(if1.y_out), q1.pop_front());
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic load(input int c);
    @(posedge clk); #1 coef_load = 1'b1; coef_in = 4'(c);
    @(posedge clk); #1 coef_load = 1'b0;
  endtask

  task automatic load4(input int c);
    for (int i = 0; i < N; i++) load(c);
  endtask

  task automatic push_exp(input int e);
    if (sel) q1.push_back(e);
    else     q0.push_back(e);
  endtask

  // Called right after the edge that samples in_valid; cnt counts that edge as 1.
  task automatic wait_out(output int cnt, output int busy_n);
    bit got = 1'b0;
    cnt = 1; busy_n = 0;
    while (!got && cnt < 40) begin
      @(negedge clk);
      if (busy_m) busy_n++;
      if (out_valid_m) got = 1'b1;
      else begin
        @(posedge clk);
        cnt++;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout got none expected pulse");
    end
  endtask

  task automatic send(input int x, input int e, input bit chk_lat);
    int cnt, busy_n;
    @(posedge clk); #1 x_in = 4'(x); in_valid = 1'b1;
    push_exp(e);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out(cnt, busy_n);
    if (chk_lat) begin
      check("latency", cnt, N + 1);
      check("busy_cycles", busy_n, N);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end

  initial begin
    int cnt, busy_n, ov;

    do_reset();
    @(negedge clk);
    check("rst_y_out0", int'(if0.y_out), 0);
    check("rst_y_out1", int'(if1.y_out), 0);
    check("rst_out_valid", int'(if0.out_valid), 0);
    check("rst_busy", int'(if0.busy), 0);
    check("rst_overrun", int'(if0.overrun), 0);

    // Default taps: difference filter.
    send(3, -3, 1);
    send(5, -2, 1);
    repeat (3) @(negedge clk);
    check("y_hold", int'(if0.y_out), -2);

    do_reset();
    load4(1);
    send(1, 1, 0);
    send(2, 3, 0);
    send(3, 6, 0);
    send(4, 10, 0);
    send(5, 14, 1);

    do_reset();
    load4(-8);
    for (int i = 0; i < 4; i++) send(-8, (i == 0) ? 64 : 127, 0);
    do_reset();
    load4(-8);
    send(7, -56, 0);
    send(7, -112, 0);
    send(7, -128, 0);

    // Sample two cycles into a MAC is dropped.
    do_reset();
    @(negedge clk);
    check("overrun_clear", int'(overrun_m), 0);
    @(posedge clk); #1 x_in = 4'(3); in_valid = 1'b1;
    push_exp(-3);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 x_in = 4'(6); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out(cnt, busy_n);
    @(negedge clk);
    check("overrun_mac", int'(overrun_m), 1);

    // Load and sample together: load wins.
    do_reset();
    @(posedge clk); #1 coef_load = 1'b1; coef_in = 4'(5); x_in = 4'(7); in_valid = 1'b1;
    @(posedge clk); #1 coef_load = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("collide_busy", int'(busy_m), 0);
    check("collide_overrun", int'(overrun_m), 1);
    send(2, 2, 1);

    // Reset in the middle of a MAC.
    do_reset();
    @(posedge clk); #1 x_in = 4'(4); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    ov = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid_m) ov++;
    end
    check("midmac_no_out", ov, 0);
    check("midmac_busy", int'(busy_m), 0);
    send(3, -3, 1);

    // SHIFT=2 instance with unit taps.
    sel = 1'b1;
    do_reset();
    load4(1);
    send(1, 0, 0);
    send(2, 1, 0);
    send(3, 2, 1);
    do_reset();
    load4(1);
    send(-1, 0, 0);
    send(-2, -1, 0);
    send(-3, -1, 0);

    repeat (6) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_mac_prog.md
# fir_mac_prog

Parametrised, coefficient-programmable N-tap FIR filter for the signal-processing project. It replaces the fixed two-tap difference filter with a single time-multiplexed multiply-accumulate engine: a valid/busy handshake on the sample input, and round/saturate on the output. Its reset coefficients reproduce the existing y[n] = x[n-1] − x[n] response, so it drops into the current I/O mapping unchanged.

## Interface
- N_TAPS, 4, number of taps (≥2)
- BW_in, 4, signed sample width
- BW_coef, 4, signed coefficient width
- BW_out, 8, signed output width
- SHIFT, 0, arithmetic right shift applied to the accumulator before output
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- x_in  in  BW_in  signed sample
- in_valid  in  1  sample strobe
- coef_load  in  1  shift coef_in into the coefficient chain
- coef_in  in  BW_coef  signed coefficient word
- y_out  out  BW_out  signed filtered output, registered
- out_valid  out  1  one-cycle pulse when y_out updates
- busy  out  1  high while the MAC is running
- overrun  out  1  sticky; a sample or load was dropped

## Operation
- Reset (clk, reset: synchronous, active-high) sets:
  - delay line x[0..N-1] = 0; y_out = 0; out_valid = 0; busy = 0; overrun = 0; state IDLE.
  - Coefficients h[0] = −1, h[1] = +1, all others 0.
- Widths:
  - Product width is BW_in+BW_coef.
  - Accumulator width is BW_in+BW_coef+clog2(N_TAPS), so it never wraps.
- Output path: add 2^(SHIFT−1) when SHIFT>0, arithmetic shift right by SHIFT, then saturate to [−2^(BW_out−1), 2^(BW_out−1)−1].
- FSM states are IDLE and MAC.
- IDLE:
  - If coef_load=1: h[N−1]←coef_in and h[k]←h[k+1]. After N loads, the first word loaded sits in h[0].
  - Else if in_valid=1: x[0]←x_in, x[k]←x[k−1]; acc←0; idx←0; go to MAC.
  - If coef_load and in_valid are both 1: the load wins, the sample is dropped, and overrun is set.
- MAC:
  - Each cycle acc←acc+x[idx]·h[idx] and idx←idx+1.
  - On idx=N−1: y_out←sat(round(acc + x[N−1]·h[N−1])), out_valid←1, return to IDLE.
  - in_valid or coef_load during MAC is ignored, and overrun←1.
- busy = (state==MAC).
- overrun is cleared only by reset.

## Timing
- Latency:
  - in_valid is sampled at edge t, and MAC runs during cycles t+1 … t+N_TAPS.
  - y_out and out_valid are updated at edge t+N_TAPS and stay valid for that one cycle; out_valid is 0 otherwise.
  - y_out holds its value until the next update.
- Throughput is one sample per N_TAPS+1 cycles. During the out_valid cycle the FSM is already in IDLE and may accept the next sample.
- A coefficient load takes effect for any sample accepted on a later edge.
- Reset mid-MAC: the result is discarded, out_valid stays 0, and coefficients and the delay line return to their reset values.

## Test plan
- Defaults, reset coefficients: samples 3, then 5, with each new sample sent only after out_valid → y_out = −3, then −2. Each out_valid arrives exactly N_TAPS+1 cycles after its in_valid, and busy is high for exactly N_TAPS cycles.
- Load coefficients 1,1,1,1, then samples 1,2,3,4,5 → y_out = 1, 3, 6, 10, 14.
- Saturation, coefficients all −8:
  - Samples −8 ×4 → y_out = 64, 127, 127, 127.
  - After reset and reloading −8 ×4, samples 7,7,7 → y_out = −56, −112, −128.
- Overrun: pulse in_valid (x=6) two cycles after an accepted sample → sample dropped, overrun=1, and the pending output is unchanged. Simultaneous coef_load+in_valid in IDLE → coefficient loaded, overrun=1.
- Reset asserted mid-MAC → no out_valid; the next sample 3 gives −3, confirming coefficients are back to defaults.
- SHIFT=2 build, coefficients 1,1,1,1:
  - Samples 1,2,3 (accumulator 6 on the third) → third y_out = 2.
  - After reset and reloading, samples −1,−2,−3 → third y_out = −1.
